// File: rtl/sw_led_array.sv
// sw_led_array: debounced switch bank driving an LED bank.
//
// A free-running divider produces a one-clk scan tick every DIV_RATIO clks.
// Each raw switch passes through a two-flop synchronizer. On every tick the
// synchronized value is compared with the accepted ("stable") level, and a
// change is accepted only after DEB_CNT consecutive differing samples. Accepted
// 0->1 transitions produce a one-clk press pulse and flip a per-channel toggle
// bit. The LED register selects its source according to mode.
//
// Optional feature: define SW_LED_BLINK_EN to build the blink counter and
// phase bit used by mode 10. Without it, mode 10 shows the stable level
// (same as mode 00).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   sw     in   [CH] raw asynchronous switches
//   mode   in   [2]  00 direct, 01 toggle, 10 blink-while-held, 11 off
//   clr    in   synchronous clear of all toggle bits (wins over a press)
//   led    out  [CH] registered LED drive
//   press  out  [CH] one-clk pulse per accepted 0->1 switch transition
module sw_led_array #(
  parameter int CH          = 4,
  parameter int DIV_RATIO   = 10000,
  parameter int DEB_CNT     = 4,
  parameter int BLINK_TICKS = 2500
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sw,
  input  logic [1:0]    mode,
  input  logic          clr,
  output logic [CH-1:0] led,
  output logic [CH-1:0] press
);

  localparam int TICK_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam int CNT_W  = $clog2(DEB_CNT + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CNT - 1);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [CH-1:0]     sync1_q, sync1_d;
  logic [CH-1:0]     sync2_q, sync2_d;
  logic [CH-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [CH];
  logic [CNT_W-1:0]  cnt_d [CH];
  logic [CH-1:0]     press_q, press_d;
  logic [CH-1:0]     tog_q, tog_d;
  logic [CH-1:0]     led_q, led_d;
  logic [CH-1:0]     blink_src;

`ifdef SW_LED_BLINK_EN
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               phase_q, phase_d;
`endif

  always_comb begin
    // Scan-tick divider: tick is high for the single clk the counter sits at
    // its last value, so the first tick takes effect DIV_RATIO clks after reset.
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    sync1_d = sw;
    sync2_d = sync1_q;

    // Debounce: a matching sample restarts the run of differing samples; the
    // DEB_CNT-th consecutive differing sample is accepted.
    stable_d = stable_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // Rising edge of the accepted level; registered so press is high in the
    // same clk that stable shows the new level.
    press_d = stable_d & ~stable_q;
    tog_d   = clr ? '0 : (tog_q ^ press_d);

`ifdef SW_LED_BLINK_EN
    blink_d = blink_q;
    phase_d = phase_q;
    if (tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BLINK_W'(1);
      end
    end
    blink_src = stable_q & {CH{phase_q}};
`else
    blink_src = stable_q;
`endif

    unique case (mode)
      2'b00:   led_d = stable_q;
      2'b01:   led_d = tog_q;
      2'b10:   led_d = blink_src;
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
      press_q    <= '0;
      tog_q      <= '0;
      led_q      <= '0;
`ifdef SW_LED_BLINK_EN
      blink_q    <= '0;
      phase_q    <= 1'b0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
      press_q    <= press_d;
      tog_q      <= tog_d;
      led_q      <= led_d;
`ifdef SW_LED_BLINK_EN
      blink_q    <= blink_d;
      phase_q    <= phase_d;
`endif
    end
  end

  assign led   = led_q;
  assign press = press_q;

endmodule

// File: tb/tb_sw_led_array.sv
// Testbench for sw_led_array (CH=4, DIV_RATIO=4, DEB_CNT=3, BLINK_TICKS=2).
// A behavioural model tracks edges since reset, a short history of switch
// values, runs of differing samples and the total tick count; it is compared
// against the DUT after every clock edge, alongside table vectors and
// hand-written corner-case sequences.
module tb_sw_led_array;
  localparam int CH    = 4;
  localparam int DIV   = 4;
  localparam int DEB   = 3;
  localparam int BLINK = 2;

  logic          clk  = 1'b0;
  logic          rst  = 1'b0;
  logic [CH-1:0] sw   = '0;
  logic [1:0]    mode = 2'b00;
  logic          clr  = 1'b0;
  logic [CH-1:0] led;
  logic [CH-1:0] press;

  sw_led_array #(.CH(CH), .DIV_RATIO(DIV), .DEB_CNT(DEB), .BLINK_TICKS(BLINK)) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode), .clr(clr), .led(led), .press(press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_n;
  int            m_ticks;
  int            m_run [CH];
  logic [CH-1:0] m_stable, m_tog, m_led, m_press;
  logic [CH-1:0] m_hist[$];

  task automatic model_reset();
    m_n = 0; m_ticks = 0;
    m_stable = '0; m_tog = '0; m_led = '0; m_press = '0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    logic [CH-1:0] samp, nstable, nled;
    if (!rst) begin
      model_reset();
      return;
    end
    case (mode)
      2'b00: nled = m_stable;
      2'b01: nled = m_tog;
`ifdef SW_LED_BLINK_EN
      2'b10: nled = (((m_ticks / BLINK) % 2) == 1) ? m_stable : '0;
`else
      2'b10: nled = m_stable;
`endif
      default: nled = '0;
    endcase
    m_n++;
    nstable = m_stable;
    if (m_n % DIV == 0) begin
      samp = (m_hist.size() >= 2) ? m_hist[1] : '0;
      for (int c = 0; c < CH; c++) begin
        if (samp[c] == m_stable[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            nstable[c] = samp[c];
            m_run[c]   = 0;
          end
        end
      end
      m_ticks++;
    end
    m_press  = nstable & ~m_stable;
    m_tog    = clr ? '0 : (m_tog ^ m_press);
    m_stable = nstable;
    m_led    = nled;
    m_hist.push_front(sw);
    if (m_hist.size() > 2) void'(m_hist.pop_back());
  endtask

  function automatic logic predict_press(input int ch);
    logic [CH-1:0] s;
    if (!rst || ((m_n + 1) % DIV) != 0 || m_hist.size() < 2) return 1'b0;
    s = m_hist[1];
    return s[ch] && !m_stable[ch] && (m_run[ch] + 1 >= DEB);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("model_led", led, m_led);
      check("model_press", press, m_press);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [CH-1:0] sw;
    logic [1:0]    mode;
    logic          clr;
    int            cycles;
    logic [CH-1:0] exp_led;
    logic [CH-1:0] exp_press;
  } vec_t;
  vec_t vt[$];

  task automatic add_vec(input logic [CH-1:0] s, input logic [1:0] m, input logic c,
                         input int n, input logic [CH-1:0] el, input logic [CH-1:0] ep);
    vec_t v;
    v.sw = s; v.mode = m; v.clr = c; v.cycles = n; v.exp_led = el; v.exp_press = ep;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, npress, anyp, anyl, seen, hi, lo, reached;
    logic [CH-1:0] por, p12;
    logic prev, all1;

    model_reset();
    // Reset held: everything low.
    cyc(3);
    check("reset_led", led, 0);
    check("reset_press", press, 0);
    rst = 1'b1;

    // sw[0] accepted, one press, led follows.
    sw = 4'b0001; lat = 0; npress = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      if (press[0]) npress++;
      if (led[0] && lat == 0) lat = i;
    end
    check("first_led_lat_ok", (lat > 0 && lat <= 18), 1);
    check("first_press_once", npress, 1);
    check("first_led", led, 4'b0001);

    // State now: stable=0001 tog=0001.
    add_vec(4'b0000, 2'b00, 1'b0, 24, 4'b0000, 4'b0000);
    add_vec(4'b0000, 2'b01, 1'b0,  4, 4'b0001, 4'b0000);
    add_vec(4'b0000, 2'b01, 1'b1,  4, 4'b0000, 4'b0000);
    add_vec(4'b0100, 2'b01, 1'b0, 24, 4'b0100, 4'b0100);
    add_vec(4'b0000, 2'b01, 1'b0, 24, 4'b0100, 4'b0000);
    add_vec(4'b0100, 2'b01, 1'b0, 24, 4'b0000, 4'b0100);
    add_vec(4'b0000, 2'b01, 1'b0, 24, 4'b0000, 4'b0000);
    add_vec(4'b0100, 2'b01, 1'b0, 24, 4'b0100, 4'b0100);
    add_vec(4'b0000, 2'b01, 1'b0, 24, 4'b0100, 4'b0000);
    add_vec(4'b1111, 2'b11, 1'b0, 24, 4'b0000, 4'b1111);
    add_vec(4'b1111, 2'b00, 1'b0,  4, 4'b1111, 4'b0000);
    add_vec(4'b0000, 2'b00, 1'b0, 24, 4'b0000, 4'b0000);
    for (int v = 0; v < vt.size(); v++) begin
      sw = vt[v].sw; mode = vt[v].mode; clr = vt[v].clr;
      por = '0;
      for (int k = 0; k < vt[v].cycles; k++) begin
        cyc(1);
        por |= press;
      end
      check($sformatf("vec%0d_led", v), led, vt[v].exp_led);
      check($sformatf("vec%0d_press", v), por, vt[v].exp_press);
    end
    clr = 1'b0;

    // Glitch on sw[1] lasting 8 clks (two ticks) must be ignored.
    anyp = 0; anyl = 0;
    sw = 4'b0010;
    for (int i = 0; i < 8; i++) begin cyc(1); if (press != 0) anyp = 1; if (led[1]) anyl = 1; end
    sw = 4'b0000;
    for (int i = 0; i < 24; i++) begin cyc(1); if (press != 0) anyp = 1; if (led[1]) anyl = 1; end
    check("glitch_press", anyp, 0);
    check("glitch_led1", anyl, 0);

    // Toggle mode: set tog[2], then a press with clr in the same clk.
    mode = 2'b01;
    sw = 4'b0100; cyc(24);
    check("tog2_set", led[2], 1'b1);
    sw = 4'b0000; cyc(24);
    sw = 4'b0100; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      clr = predict_press(2);
      cyc(1);
      if (clr) begin
        seen = 1;
        check("clr_press_pulse", press[2], 1'b1);
      end
      clr = 1'b0;
    end
    check("clr_press_seen", seen, 1);
    cyc(3);
    check("clr_wins_led", led, 4'b0000);

    // Blink-while-held on sw[3].
    mode = 2'b10; sw = 4'b1000;
    cyc(20);
`ifdef SW_LED_BLINK_EN
    prev = led[3]; hi = 0; lo = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (!prev && led[3]) break;
      prev = led[3];
    end
    hi = 1;
    for (int i = 0; i < 40; i++) begin cyc(1); if (led[3]) hi++; else break; end
    lo = 1;
    for (int i = 0; i < 40; i++) begin cyc(1); if (!led[3]) lo++; else break; end
    check("blink_high_len", hi, 8);
    check("blink_low_len", lo, 8);
`else
    all1 = 1'b1;
    for (int i = 0; i < 32; i++) begin cyc(1); if (!led[3]) all1 = 1'b0; end
    check("noblink_led3", all1, 1'b1);
`endif

    // Reset in the middle of a debounce run.
    mode = 2'b00;
    cyc(4);
    check("pre_rst_led", led, 4'b1000);
    sw = 4'b1001; reached = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (m_run[0] == 2) begin reached = 1; break; end
    end
    check("deb_run2_reached", reached, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_async_led", led, 0);
    check("rst_async_press", press, 0);
    cyc(2);
    rst = 1'b1;
    lat = 0; p12 = '0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      if (i == 12) p12 = press;
      if (led[0] && lat == 0) lat = i;
    end
    check("rst_deb_lat", lat, 13);
    check("rst_held_press", p12, 4'b1001);

    // Off mode: presses still pulse, led stays dark.
    mode = 2'b11; sw = 4'b0000; cyc(24);
    sw = 4'b1111; por = '0; anyl = 0;
    for (int i = 0; i < 24; i++) begin cyc(1); por |= press; if (led != 0) anyl = 1; end
    check("off_led", anyl, 0);
    check("off_press", por, 4'b1111);

    // Randomised traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        int idx;
        idx = $urandom_range(0, CH - 1);
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check("rand_rst_led", led, 0);
        cyc(1);
        rst = 1'b1;
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
